// File: rtl/ffapuf_pkg.sv
// Shared types and constants for the FF-APUF challenge/response controller.
// The LFSR step function lives here so the sub-module and any future model agree on it.
package ffapuf_pkg;

  localparam int unsigned CR_W = 32;

  // Fibonacci taps 32/22/2/1 -> bit positions 31, 21, 1, 0.
  localparam logic [CR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [CR_W-1:0] NONZERO_SEED = 32'h0000_0001;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StEval,
    StOut,
    StDone
  } state_e;

  function automatic logic [CR_W-1:0] lfsr_next(input logic [CR_W-1:0] c);
    logic fb;
    fb = ^(c & LFSR_TAPS);
    return {c[CR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/ffapuf_lfsr32.sv
// 32-bit Fibonacci LFSR that generates the PUF challenge sequence.
// Loading a zero seed substitutes NONZERO_SEED so the register can never lock up.
module ffapuf_lfsr32
  import ffapuf_pkg::*;
(
  input  logic            clk,
  input  logic            clear,
  input  logic            load,
  input  logic [CR_W-1:0] seed,
  input  logic            step,
  output logic [CR_W-1:0] value
);

  logic [CR_W-1:0] value_q;

  // The reset value of zero is never stepped: a load always comes first.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= (seed == '0) ? NONZERO_SEED : seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ffapuf_crp_ctrl.sv
// Drives LFSR challenges into the FF-APUF, sequences clear/settle, captures the response
// and streams each challenge/response pair out over a valid/ready interface.
module ffapuf_crp_ctrl
  import ffapuf_pkg::*;
#(
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [CR_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_crp,
  output logic             busy,
  output logic             done,
  output logic             puf_clr,
  output logic [CR_W-1:0]  puf_c,
  input  logic [CR_W-1:0]  puf_o,
  output logic             crp_valid,
  input  logic             crp_ready,
  output logic [CR_W-1:0]  crp_chal,
  output logic [CR_W-1:0]  crp_resp,
  output logic [CNT_W-1:0] crp_idx
);

  localparam int unsigned PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam logic [PH_W-1:0] CLR_LAST    = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CR_W-1:0]  chal_q, chal_d;
  logic [CR_W-1:0]  resp_q, resp_d;
  logic [CNT_W-1:0] cidx_q, cidx_d;
  logic             zdone_q, zdone_d;
  logic             lfsr_load;
  logic             lfsr_step;
  logic [CR_W-1:0]  lfsr_value;

  // The LFSR only moves on ARM entry, so its value is the held challenge.
  ffapuf_lfsr32 u_lfsr (
    .clk   (clk),
    .clear (clear),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    num_d     = num_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    cidx_d    = cidx_q;
    zdone_d   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_crp != '0) begin
            num_d     = num_crp;
            idx_d     = '0;
            ph_d      = '0;
            lfsr_load = 1'b1;
            state_d   = StArm;
          end else begin
            // Zero-length request: report completion without leaving IDLE.
            zdone_d = 1'b1;
          end
        end
      end
      StArm: begin
        if (ph_q == CLR_LAST) begin
          ph_d    = '0;
          state_d = StEval;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      StEval: begin
        if (ph_q == SETTLE_LAST) begin
          resp_d  = puf_o;
          chal_d  = lfsr_value;
          cidx_d  = idx_q;
          ph_d    = '0;
          state_d = StOut;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      StOut: begin
        if (crp_ready) begin
          if (idx_q == num_q - CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            lfsr_step = 1'b1;
            idx_d     = idx_q + CNT_W'(1);
            state_d   = StArm;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      ph_q    <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      cidx_q  <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      cidx_q  <= cidx_d;
      zdone_q <= zdone_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone) | zdone_q;
  assign puf_clr   = (state_q != StEval);
  assign puf_c     = lfsr_value;
  assign crp_valid = (state_q == StOut);
  assign crp_chal  = chal_q;
  assign crp_resp  = resp_q;
  assign crp_idx   = cidx_q;

endmodule

// File: tb/tb_ffapuf_crp_ctrl.sv
// Scoreboard bench for ffapuf_crp_ctrl: directed runs push expected CRPs, a monitor pops them
// on each handshake. A second instance with short timing checks clear/settle windows.
module tb_ffapuf_crp_ctrl;

  typedef struct {
    logic [31:0] chal;
    logic [31:0] resp;
    logic [15:0] idx;
  } crp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        start, start6;
  logic [31:0] seed, seed6;
  logic [15:0] num_crp, num6;
  logic        busy, busy6, done, done6;
  logic        puf_clr, puf_clr6;
  logic [31:0] puf_c, puf_c6, puf_o, puf_o6;
  logic        crp_valid, crp_valid6, crp_ready, crp_ready6;
  logic [31:0] crp_chal, crp_chal6, crp_resp, crp_resp6;
  logic [15:0] crp_idx, crp_idx6;
  logic [31:0] k6 = 32'd0;

  crp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int crp_cnt = 0;

  always #5 clk = ~clk;

  ffapuf_crp_ctrl dut (
    .clk (clk), .clear (clear), .start (start), .seed (seed), .num_crp (num_crp),
    .busy (busy), .done (done), .puf_clr (puf_clr), .puf_c (puf_c), .puf_o (puf_o),
    .crp_valid (crp_valid), .crp_ready (crp_ready), .crp_chal (crp_chal),
    .crp_resp (crp_resp), .crp_idx (crp_idx)
  );

  ffapuf_crp_ctrl #(.CLR_CYCLES(1), .SETTLE_CYCLES(4), .CNT_W(16)) dut6 (
    .clk (clk), .clear (clear), .start (start6), .seed (seed6), .num_crp (num6),
    .busy (busy6), .done (done6), .puf_clr (puf_clr6), .puf_c (puf_c6), .puf_o (puf_o6),
    .crp_valid (crp_valid6), .crp_ready (crp_ready6), .crp_chal (crp_chal6),
    .crp_resp (crp_resp6), .crp_idx (crp_idx6)
  );

  // Main PUF model: response is the inverted challenge.
  assign puf_o = ~puf_c;

  // Timing PUF model: response encodes which low-clr cycle is in progress (1-based).
  initial forever begin
    @(posedge clk);
    k6 <= puf_clr6 ? 32'd0 : k6 + 32'd1;
  end
  assign puf_o6 = 32'hC0DE_0000 + k6 + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] r, input logic [15:0] i);
    crp_t e;
    e.chal = c;
    e.resp = r;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] s, input logic [15:0] n);
    seed    = s;
    num_crp = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard monitor: compare on every handshake, sampled on the falling edge.
  initial forever begin
    crp_t e;
    @(negedge clk);
    if (done) done_cnt++;
    if (crp_valid && crp_ready) begin
      crp_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL crp_unexpected: got chal %0h idx %0d expected no CRP", crp_chal, crp_idx);
      end else begin
        e = exp_q.pop_front();
        chk("crp_chal", 64'(crp_chal), 64'(e.chal));
        chk("crp_resp", 64'(crp_resp), 64'(e.resp));
        chk("crp_idx", 64'(crp_idx), 64'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    int c0;
    int bad;
    logic [31:0] hc, hr, hp;
    logic [15:0] hi;

    clear = 1'b1; start = 1'b0; seed = '0; num_crp = '0; crp_ready = 1'b1;
    start6 = 1'b0; seed6 = '0; num6 = '0; crp_ready6 = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_puf_clr", 64'(puf_clr), 64'd1);
    chk("rst_puf_c", 64'(puf_c), 64'd0);
    chk("rst_valid", 64'(crp_valid), 64'd0);
    chk("rst_chal", 64'(crp_chal), 64'd0);
    chk("rst_resp", 64'(crp_resp), 64'd0);
    chk("rst_idx", 64'(crp_idx), 64'd0);
    clear = 1'b0;
    tick();

    // 1: clear mid-EVAL aborts silently.
    d0 = done_cnt;
    c0 = crp_cnt;
    do_start(32'hDEAD_BEEF, 16'd5);
    tick();
    tick();
    chk("t1_busy_eval", 64'(busy), 64'd1);
    chk("t1_clr_low_eval", 64'(puf_clr), 64'd0);
    clear = 1'b1;
    tick(); tick(); tick();
    clear = 1'b0;
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_puf_clr", 64'(puf_clr), 64'd1);
    chk("t1_valid", 64'(crp_valid), 64'd0);
    chk("t1_puf_c", 64'(puf_c), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("t1_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t1_no_crp", 64'(crp_cnt - c0), 64'd0);

    // 2: seed 1, three CRPs, ready high.
    push(32'h0000_0001, 32'hFFFF_FFFE, 16'd0);
    push(32'h0000_0003, 32'hFFFF_FFFC, 16'd1);
    push(32'h0000_0006, 32'hFFFF_FFF9, 16'd2);
    d0 = done_cnt;
    c0 = crp_cnt;
    do_start(32'h0000_0001, 16'd3);
    n = 1;
    while (!crp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t2_first_valid_latency", 64'(n), 64'd11);
    wait_done("t2_done", 200);
    tick(); tick(); tick();
    chk("t2_crp_count", 64'(crp_cnt - c0), 64'd3);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_busy_idle", 64'(busy), 64'd0);

    // 3: zero seed substitutes 1.
    push(32'h0000_0001, 32'hFFFF_FFFE, 16'd0);
    do_start(32'h0000_0000, 16'd1);
    wait_done("t3_done", 100);
    tick(); tick();
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: back-pressure on the first CRP.
    push(32'h1234_5678, 32'hEDCB_A987, 16'd0);
    push(32'h2468_ACF1, 32'hDB97_530E, 16'd1);
    c0 = crp_cnt;
    crp_ready = 1'b0;
    do_start(32'h1234_5678, 16'd2);
    n = 0;
    while (!crp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t4_valid_seen", 64'(crp_valid), 64'd1);
    hc = crp_chal; hr = crp_resp; hi = crp_idx; hp = puf_c;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!crp_valid || crp_chal !== hc || crp_resp !== hr || crp_idx !== hi || puf_c !== hp)
        bad++;
    end
    chk("t4_stall_hold_bad_cycles", 64'(bad), 64'd0);
    chk("t4_stall_chal", 64'(hc), 64'h1234_5678);
    chk("t4_no_crp_while_stalled", 64'(crp_cnt - c0), 64'd0);
    crp_ready = 1'b1;
    wait_done("t4_done", 200);
    tick(); tick();
    chk("t4_crp_count", 64'(crp_cnt - c0), 64'd2);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5a: zero-length request.
    d0 = done_cnt;
    c0 = crp_cnt;
    do_start(32'h0000_0001, 16'd0);
    chk("t5_done_next_cycle", 64'(done), 64'd1);
    chk("t5_busy_with_done", 64'(busy), 64'd0);
    tick();
    chk("t5_done_one_cycle", 64'(done), 64'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (crp_valid || busy) bad++;
      tick();
    end
    chk("t5_quiet_bad_cycles", 64'(bad), 64'd0);
    chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);

    // 5b: start while busy is ignored.
    push(32'h0000_0001, 32'hFFFF_FFFE, 16'd0);
    push(32'h0000_0003, 32'hFFFF_FFFC, 16'd1);
    c0 = crp_cnt;
    do_start(32'h0000_0001, 16'd2);
    tick(); tick(); tick(); tick();
    do_start(32'hFFFF_FFFF, 16'd7);
    wait_done("t5b_done", 200);
    tick(); tick();
    chk("t5b_crp_count", 64'(crp_cnt - c0), 64'd2);
    chk("t5b_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: CLR_CYCLES=1, SETTLE_CYCLES=4 timing and sample point.
    seed6 = 32'h0000_0001;
    num6 = 16'd2;
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (puf_clr6 && n < 20) begin
        tick();
        n++;
      end
      chk("t6_clr_high_cycles", 64'(n), 64'd1);
      n = 0;
      while (!puf_clr6 && n < 20) begin
        tick();
        n++;
      end
      chk("t6_clr_low_cycles", 64'(n), 64'd4);
      chk("t6_valid", 64'(crp_valid6), 64'd1);
      chk("t6_resp_cycle4", 64'(crp_resp6), 64'hC0DE_0004);
      chk("t6_idx", 64'(crp_idx6), 64'(c));
      chk("t6_chal", 64'(crp_chal6), (c == 0) ? 64'h1 : 64'h3);
      if (c == 0) begin
        hp = puf_c6;
        n = 0;
        while (puf_c6 == hp && n < 20) begin
          tick();
          n++;
        end
      end
    end
    n = 0;
    while (!done6 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_done", 64'(done6), 64'd1);
    tick();
    chk("t6_idle", 64'(busy6), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
